fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage for a single-issue pipeline with one branch delay slot.
// Issues one instruction-memory request at a time, buffers a single response
// while ID is stalled, and steers fetch_pc on redirects without ever dropping
// the delay-slot instruction.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        valid_id
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e      state_q;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q;

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;

  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        req_fire;
  logic        resp_take;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] redirect_target;

  // The request is gated by rst_n so nothing is offered while reset is held,
  // yet the first request appears as soon as reset is released.
  assign imem_req_valid = rst_n & (state_q == IDLE) & ~buf_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses only count while a request is outstanding; anything seen in
  // IDLE is a leftover from a request abandoned by reset.
  assign resp_take      = (state_q == WAIT) & imem_resp_valid;

  // A control transfer is acted on only when ID really holds it and moves on.
  assign redirect       = valid_id_q & ~stall & (jump_reg | jump_target | jump_branch);

  assign pc_plus4       = pc_id_q + 32'd4;
  assign branch_offset  = {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};

  assign instr_id       = instr_id_q;
  assign pc_id          = pc_id_q;
  assign valid_id       = valid_id_q;

  // Pick the redirect target: register jump beats absolute jump beats branch.
  always_comb begin
    redirect_target = pc_plus4 + branch_offset;
    if (jump_reg) begin
      redirect_target = jr_pc;
    end else if (jump_target) begin
      redirect_target = {pc_plus4[31:28], instr_id_q[25:0], 2'b00};
    end
  end

  // Next fetch address. The delay slot lives at pc_id+4, so a redirect must
  // wait until that address has been handed to memory before taking effect.
  always_comb begin
    fetch_pc_d         = fetch_pc_q;
    redirect_pending_d = redirect_pending_q;
    redirect_pc_d      = redirect_pc_q;
    if (redirect) begin
      if ((fetch_pc_q == pc_plus4) && !req_fire) begin
        redirect_pending_d = 1'b1;
        redirect_pc_d      = redirect_target;
      end else begin
        fetch_pc_d         = redirect_target;
        redirect_pending_d = 1'b0;
      end
    end else if (req_fire) begin
      if (redirect_pending_q) begin
        fetch_pc_d         = redirect_pc_q;
        redirect_pending_d = 1'b0;
      end else begin
        fetch_pc_d         = fetch_pc_q + 32'd4;
      end
    end
  end

  // ID register and one-entry buffer. The buffer is older than any arriving
  // response, so it always drains into ID first.
  always_comb begin
    instr_id_d  = instr_id_q;
    pc_id_d     = pc_id_q;
    valid_id_d  = valid_id_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (!stall) begin
      if (buf_valid_q) begin
        instr_id_d  = buf_instr_q;
        pc_id_d     = buf_pc_q;
        valid_id_d  = 1'b1;
        buf_valid_d = 1'b0;
      end else if (resp_take) begin
        instr_id_d  = imem_resp_data;
        pc_id_d     = req_pc_q;
        valid_id_d  = 1'b1;
      end else begin
        instr_id_d  = 32'd0;
        valid_id_d  = 1'b0;
      end
    end
    if (resp_take && (stall || buf_valid_q)) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem_resp_data;
      buf_pc_d    = req_pc_q;
    end
  end

  // Request FSM: one outstanding fetch at a time, remembering its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_pc_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_q  <= WAIT;
            req_pc_q <= fetch_pc_q;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fetch address, redirect bookkeeping, buffer and ID register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q         <= RESET_PC;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= 32'd0;
      buf_valid_q        <= 1'b0;
      buf_instr_q        <= 32'd0;
      buf_pc_q           <= 32'd0;
      instr_id_q         <= 32'd0;
      pc_id_q            <= 32'd0;
      valid_id_q         <= 1'b0;
    end else begin
      fetch_pc_q         <= fetch_pc_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
      buf_valid_q        <= buf_valid_d;
      buf_instr_q        <= buf_instr_d;
      buf_pc_q           <= buf_pc_d;
      instr_id_q         <= instr_id_d;
      pc_id_q            <= pc_id_d;
      valid_id_q         <= valid_id_d;
    end
  end

endmodule
